// File: rtl/perm_pkg.sv
// perm_pkg: shared permission/fault bit indices, port ids, FSM encoding and counter helper
package perm_pkg;
  localparam int PERM_R = 0;
  localparam int PERM_W = 1;
  localparam int PERM_X = 2;
  localparam int FLT_NO_READ = 0;
  localparam int FLT_WR_PROT = 1;
  localparam int FLT_NO_EXEC = 2;
  localparam int FLT_PRIV_REL = 3;
  localparam int FLT_BAD_REQ = 4;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc, input logic clr);
    return clr ? 16'd0 : (inc && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction
endpackage

// File: rtl/perm_arb_if.sv
// perm_arb_if: I/D permission request ports and the check response channel
interface perm_arb_if #(parameter int TAG_W = 4);
  logic i_valid, i_ready, i_user, i_tt;
  logic [2:0] i_uperm, i_sperm;
  logic [TAG_W-1:0] i_tag;
  logic d_valid, d_ready, d_write, d_user, d_tt;
  logic [2:0] d_uperm, d_sperm;
  logic [TAG_W-1:0] d_tag;
  logic rsp_valid, rsp_ready, rsp_port, rsp_allow;
  logic [TAG_W-1:0] rsp_tag;
  logic [4:0] rsp_fault;
  modport master(
    output i_valid, i_user, i_tt, i_uperm, i_sperm, i_tag,
    output d_valid, d_write, d_user, d_tt, d_uperm, d_sperm, d_tag, rsp_ready,
    input i_ready, d_ready, rsp_valid, rsp_port, rsp_allow, rsp_tag, rsp_fault
  );
  modport slave(
    input i_valid, i_user, i_tt, i_uperm, i_sperm, i_tag,
    input d_valid, d_write, d_user, d_tt, d_uperm, d_sperm, d_tag, rsp_ready,
    output i_ready, d_ready, rsp_valid, rsp_port, rsp_allow, rsp_tag, rsp_fault
  );
endinterface

// File: rtl/perm_check.sv
// perm_check: combinational 68k MMU permission check for one one-hot {x,w,r} operation
module perm_check
  import perm_pkg::*;
(
  input  logic       user,
  input  logic       tt,
  input  logic [2:0] uperm,
  input  logic [2:0] sperm,
  input  logic [2:0] op,
  output logic       allow,
  output logic [4:0] fault
);
  logic [2:0] bank, miss;
  always_comb begin
    bank = user ? uperm : sperm;
    miss = tt ? 3'b000 : op & ~bank;
    allow = tt | (|(op & bank));
    fault = '0;
    fault[FLT_NO_READ] = miss[PERM_R];
    fault[FLT_WR_PROT] = miss[PERM_W];
    fault[FLT_NO_EXEC] = miss[PERM_X];
    fault[FLT_PRIV_REL] = ~allow & user & (|(op & sperm));
    fault[FLT_BAD_REQ] = ~tt & ~$onehot(op);
  end
endmodule

// File: rtl/perm_arb.sv
// perm_arb: arbitrates I/D permission requests onto one shared checker with sticky fault record
// Optional PERM_STATS_EN adds saturating check/deny counters and stat_clr.
module perm_arb
  import perm_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int ARB_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  perm_arb_if.slave        bus,
  input  logic             flt_clr,
  output logic             flt_valid,
  output logic             flt_ovf,
  output logic             flt_port,
  output logic [TAG_W-1:0] flt_tag,
  output logic [4:0]       flt_code
`ifdef PERM_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [15:0]      stat_i_chk,
  output logic [15:0]      stat_d_chk,
  output logic [15:0]      stat_i_deny,
  output logic [15:0]      stat_d_deny
`endif
);
  state_t state, state_n;
  logic gnt_i, gnt_d, last_d;
  logic op_port, op_user, op_tt;
  logic [2:0] op_req, op_uperm, op_sperm;
  logic [TAG_W-1:0] op_tag;
  logic chk_allow, deny;
  logic [4:0] chk_fault;
  perm_check u_chk (
    .user(op_user), .tt(op_tt), .uperm(op_uperm), .sperm(op_sperm), .op(op_req),
    .allow(chk_allow), .fault(chk_fault)
  );
  // Grants only leave IDLE; round-robin favours the port that did not win last time.
  always_comb begin
    gnt_i = !rst && state == IDLE && bus.i_valid && (ARB_MODE != 0 || !bus.d_valid || last_d);
    gnt_d = !rst && state == IDLE && bus.d_valid && !gnt_i;
    state_n = state;
    if (state == IDLE && (gnt_i || gnt_d)) state_n = CHECK;
    else if (state == CHECK) state_n = RESP;
    else if (state == RESP && bus.rsp_ready) state_n = IDLE;
  end
  assign bus.i_ready = gnt_i;
  assign bus.d_ready = gnt_d;
  assign deny = state == CHECK && !chk_allow;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= PORT_D;
      {op_port, op_user, op_tt, op_req, op_uperm, op_sperm, op_tag} <= '0;
      {bus.rsp_valid, bus.rsp_port, bus.rsp_allow, bus.rsp_tag, bus.rsp_fault} <= '0;
      {flt_valid, flt_ovf, flt_port, flt_tag, flt_code} <= '0;
    end else begin
      if (gnt_i || gnt_d) begin
        last_d <= gnt_d;
        op_port <= gnt_d;
        op_user <= gnt_d ? bus.d_user : bus.i_user;
        op_tt <= gnt_d ? bus.d_tt : bus.i_tt;
        op_uperm <= gnt_d ? bus.d_uperm : bus.i_uperm;
        op_sperm <= gnt_d ? bus.d_sperm : bus.i_sperm;
        op_tag <= gnt_d ? bus.d_tag : bus.i_tag;
        op_req <= gnt_d ? {1'b0, bus.d_write, ~bus.d_write} : 3'b100;
      end
      if (state == CHECK) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_port <= op_port;
        bus.rsp_tag <= op_tag;
        bus.rsp_allow <= chk_allow;
        bus.rsp_fault <= chk_fault;
      end else if (state == RESP && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
      // A clear coinciding with a new fault lets the new fault become the first record.
      if (deny && (flt_clr || !flt_valid)) begin
        flt_valid <= 1'b1;
        flt_ovf <= 1'b0;
        flt_port <= op_port;
        flt_tag <= op_tag;
        flt_code <= chk_fault;
      end else if (deny) begin
        flt_ovf <= 1'b1;
      end else if (flt_clr) begin
        flt_valid <= 1'b0;
        flt_ovf <= 1'b0;
      end
    end
  end
`ifdef PERM_STATS_EN
  logic chk;
  assign chk = state == CHECK;
  always_ff @(posedge clk) begin
    stat_i_chk <= sat_inc(stat_i_chk, chk && op_port == PORT_I, rst || stat_clr);
    stat_d_chk <= sat_inc(stat_d_chk, chk && op_port == PORT_D, rst || stat_clr);
    stat_i_deny <= sat_inc(stat_i_deny, deny && op_port == PORT_I, rst || stat_clr);
    stat_d_deny <= sat_inc(stat_d_deny, deny && op_port == PORT_D, rst || stat_clr);
  end
`endif
endmodule

// File: tb/tb_perm_arb.sv
// tb_perm_arb: directed vector table plus arbitration, fault-record, stall and reset sequences
module tb_perm_arb;
  logic clk = 0, rst = 1;
  logic flt_clr = 0, flt_valid, flt_ovf, flt_port;
  logic [3:0] flt_tag;
  logic [4:0] flt_code;
  logic f1_valid, f1_ovf, f1_port;
  logic [3:0] f1_tag;
  logic [4:0] f1_code;
`ifdef PERM_STATS_EN
  logic stat_clr = 0;
  logic [15:0] s0a, s0b, s0c, s0d, s1a, s1b, s1c, s1d;
`endif
  int checks = 0, errors = 0;
  perm_arb_if #(.TAG_W(4)) bus ();
  perm_arb_if #(.TAG_W(4)) bus1 ();
  perm_arb #(.TAG_W(4), .ARB_MODE(0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flt_clr(flt_clr), .flt_valid(flt_valid), .flt_ovf(flt_ovf),
    .flt_port(flt_port), .flt_tag(flt_tag), .flt_code(flt_code)
`ifdef PERM_STATS_EN
    , .stat_clr(stat_clr), .stat_i_chk(s0a), .stat_d_chk(s0b), .stat_i_deny(s0c), .stat_d_deny(s0d)
`endif
  );
  perm_arb #(.TAG_W(4), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .bus(bus1), .flt_clr(1'b0), .flt_valid(f1_valid), .flt_ovf(f1_ovf),
    .flt_port(f1_port), .flt_tag(f1_tag), .flt_code(f1_code)
`ifdef PERM_STATS_EN
    , .stat_clr(1'b0), .stat_i_chk(s1a), .stat_d_chk(s1b), .stat_i_deny(s1c), .stat_d_deny(s1d)
`endif
  );
  always #5 clk = ~clk;

  typedef struct {
    logic d; logic wr; logic user; logic [2:0] up; logic [2:0] sp; logic tt; logic [3:0] tag;
    logic allow; logic [4:0] fault;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.i_valid = !v.d; bus.d_valid = v.d; bus.d_write = v.wr;
    bus.i_user = v.user; bus.d_user = v.user; bus.i_uperm = v.up; bus.d_uperm = v.up;
    bus.i_sperm = v.sp; bus.d_sperm = v.sp; bus.i_tt = v.tt; bus.d_tt = v.tt;
    bus.i_tag = v.tag; bus.d_tag = v.tag;
  endtask

  // Called at a negedge with DUT idle; returns at the negedge where the response is visible.
  task automatic req(input vec_t v, input logic clr_in_check);
    drive(v);
    #1 chk("grant", {bus.i_ready, bus.d_ready}, v.d ? 2'b01 : 2'b10);
    @(negedge clk);
    bus.i_valid = 0; bus.d_valid = 0; flt_clr = clr_in_check;
    #1 chk("lat_n1", bus.rsp_valid, 0);
    @(negedge clk);
    flt_clr = 0;
    #1 chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_port", bus.rsp_port, v.d);
    chk("rsp_tag", bus.rsp_tag, v.tag);
    chk("rsp_allow", bus.rsp_allow, v.allow);
    chk("rsp_fault", bus.rsp_fault, v.fault);
  endtask

  initial begin
    int gi, gf;
    vt[0] = '{1'b0, 1'b0, 1'b1, 3'b100, 3'b000, 1'b0, 4'h1, 1'b1, 5'b00000};
    vt[1] = '{1'b1, 1'b1, 1'b1, 3'b001, 3'b011, 1'b0, 4'h2, 1'b0, 5'b01010};
    vt[2] = '{1'b1, 1'b0, 1'b1, 3'b001, 3'b000, 1'b0, 4'h3, 1'b1, 5'b00000};
    vt[3] = '{1'b1, 1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 4'h4, 1'b0, 5'b00001};
    vt[4] = '{1'b0, 1'b0, 1'b0, 3'b111, 3'b011, 1'b0, 4'h5, 1'b0, 5'b00100};
    vt[5] = '{1'b0, 1'b0, 1'b1, 3'b011, 3'b100, 1'b0, 4'h6, 1'b0, 5'b01100};
    vt[6] = '{1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 4'h7, 1'b1, 5'b00000};
    vt[7] = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b010, 1'b0, 4'h8, 1'b1, 5'b00000};
    vt[8] = '{1'b1, 1'b0, 1'b1, 3'b110, 3'b001, 1'b0, 4'h9, 1'b0, 5'b01001};
    drive(vt[0]);
    bus.i_valid = 1; bus.d_valid = 1; bus.i_tag = 4'h3; bus.d_tag = 4'h4; bus.rsp_ready = 1;
    bus1.i_valid = 1; bus1.d_valid = 1; bus1.d_write = 0; bus1.i_user = 0; bus1.d_user = 0;
    bus1.i_uperm = 0; bus1.d_uperm = 0; bus1.i_sperm = 3'b111; bus1.d_sperm = 3'b111;
    bus1.i_tt = 0; bus1.d_tt = 0; bus1.i_tag = 4'h3; bus1.d_tag = 4'h4; bus1.rsp_ready = 1;
    repeat (2) @(negedge clk);
    #1 chk("rst_ready", {bus.i_ready, bus.d_ready, bus1.i_ready, bus1.d_ready}, 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_port, bus.rsp_allow, bus.rsp_tag, bus.rsp_fault}, 0);
    chk("rst_flt", {flt_valid, flt_ovf, flt_port, flt_tag, flt_code}, 0);
    @(negedge clk);
    rst = 0;
    gi = 0; gf = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.i_ready && bus.d_ready) chk("rr_both", 1, 0);
      if (bus.i_ready || bus.d_ready) begin
        chk("rr_order", bus.d_ready, gi % 2);
        gi++;
      end
      if (bus1.i_ready || bus1.d_ready) begin
        chk("fp_order", bus1.d_ready, 0);
        gf++;
      end
      @(negedge clk);
    end
    chk("rr_count", gi, 4);
    chk("fp_count", gf, 4);
    bus.i_valid = 0; bus.d_valid = 0; bus1.i_valid = 0; bus1.d_valid = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      req(vt[k], 0);
    end
    @(negedge clk);
    flt_clr = 1;
    @(negedge clk);
    flt_clr = 0;
    #1 chk("clr_valid", {flt_valid, flt_ovf}, 0);
    req(vt[1], 0);
    chk("flt1", {flt_valid, flt_ovf, flt_port, flt_tag, flt_code}, {1'b1, 1'b0, 1'b1, 4'h2, 5'b01010});
    @(negedge clk);
    req(vt[4], 0);
    chk("flt2_ovf", {flt_valid, flt_ovf, flt_port, flt_tag, flt_code}, {1'b1, 1'b1, 1'b1, 4'h2, 5'b01010});
    @(negedge clk);
    req(vt[3], 1);
    chk("flt3_clr", {flt_valid, flt_ovf, flt_port, flt_tag, flt_code}, {1'b1, 1'b0, 1'b1, 4'h4, 5'b00001});
    @(negedge clk);
    bus.rsp_ready = 0;
    drive(vt[6]);
    #1 chk("st_grant", bus.d_ready, 1);
    @(negedge clk);
    bus.d_valid = 0; bus.i_valid = 1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1 chk("st_hold", {bus.rsp_valid, bus.rsp_port, bus.rsp_tag, bus.rsp_allow, bus.rsp_fault},
             {1'b1, 1'b1, 4'h7, 1'b1, 5'b00000});
      chk("st_nogrant", {bus.i_ready, bus.d_ready}, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1;
    #1 chk("st_last", {bus.rsp_valid, bus.i_ready}, 2'b10);
    @(negedge clk);
    #1 chk("st_done", {bus.rsp_valid, bus.i_ready}, 2'b01);
    bus.i_valid = 0;
    repeat (3) @(negedge clk);
    drive(vt[4]);
    #1 chk("rm_grant", bus.i_ready, 1);
    @(negedge clk);
    bus.i_valid = 0; rst = 1;
    @(negedge clk);
    #1 chk("rm_out", {bus.rsp_valid, flt_valid, flt_ovf, flt_code, bus.i_ready, bus.d_ready}, 0);
    rst = 0;
    vt[0].tag = 4'hA;
    req(vt[0], 0);
    @(negedge clk);
    #1 chk("rm_idle", bus.rsp_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
